data_mem_responder: RTL and testbench

//  Target side of the pipeline's MEM-stage data port: accepts load/store requests, models a

---
 rtl/data_mem_responder_if.sv | 25 ++
 rtl/data_mem_responder.sv | 183 ++++++++++++++++++
 tb/tb_data_mem_responder.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_responder_if.sv
// Request/response bundle between the MEM stage (master) and the data-memory
// responder (slave). Requests are taken in one cycle when req_ready is high;
// responses are one-cycle strobes with no backpressure.
interface data_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        busy;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, busy
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err, busy
  );
endinterface

// File: rtl/data_mem_responder.sv
// Fixed-latency data RAM target for the MEM-stage data port.
// One request in flight at a time: IDLE accepts, WAIT burns WAIT_CYCLES
// cycles, RESP presents a single-cycle response. Stores are written and load
// data captured on the edge entering RESP, so a later load always sees an
// earlier store. Misaligned, out-of-range or illegal-funct3 requests return
// resp_err with zero data and leave the RAM untouched.
module data_mem_responder #(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  data_mem_responder_if.slave  bus
);

  localparam int IDX_W = ADDR_W - 2;
  localparam int DEPTH = 1 << IDX_W;

  if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
    $error("data_mem_responder: WAIT_CYCLES must be within 0..15");
  end
  if (ADDR_W < 3 || ADDR_W > 31) begin : g_bad_addr_w
    $error("data_mem_responder: ADDR_W must be within 3..31");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [3:0]  count_reg;
  logic        cap_we_reg;
  logic [2:0]  cap_funct3_reg;
  logic [31:0] cap_addr_reg;
  logic [31:0] cap_wdata_reg;
  logic        commit;

  logic [31:0] mem [DEPTH];

  // In IDLE the request on the bus is the one being served (matters when
  // WAIT_CYCLES is 0 and commit happens on the accept edge); afterwards the
  // captured copy is used.
  logic              cur_we;
  logic [2:0]        cur_funct3;
  logic [31:0]       cur_addr;
  logic [31:0]       cur_wdata;
  logic [IDX_W-1:0]  cur_idx;

  assign cur_we     = (state_reg == ST_IDLE) ? bus.req_we     : cap_we_reg;
  assign cur_funct3 = (state_reg == ST_IDLE) ? bus.req_funct3 : cap_funct3_reg;
  assign cur_addr   = (state_reg == ST_IDLE) ? bus.req_addr   : cap_addr_reg;
  assign cur_wdata  = (state_reg == ST_IDLE) ? bus.req_wdata  : cap_wdata_reg;
  assign cur_idx    = cur_addr[ADDR_W-1:2];

  // Request legality
  logic addr_hi_nz;
  logic req_err;
  assign addr_hi_nz = |(cur_addr >> ADDR_W);
  assign req_err = (cur_funct3 == 3'b011) || (cur_funct3[2:1] == 2'b11)
                || (cur_we && cur_funct3[2])
                || ((cur_funct3[1:0] == 2'b01) && cur_addr[0])
                || ((cur_funct3[1:0] == 2'b10) && (cur_addr[1:0] != 2'b00))
                || addr_hi_nz;

  // Store lane enables and lane data: bytes replicate to all lanes, halves to
  // both lane pairs, so the enable alone picks the destination.
  logic [3:0]  st_be;
  logic [31:0] st_data;
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign st_be[gi] = (cur_funct3[1:0] == 2'b00) ? (cur_addr[1:0] == 2'(gi))
                     : (cur_funct3[1:0] == 2'b01) ? (cur_addr[1] == gi[1])
                     : (cur_funct3[1:0] == 2'b10);
    assign st_data[gi*8 +: 8] = (cur_funct3[1:0] == 2'b00) ? cur_wdata[7:0]
                              : (cur_funct3[1:0] == 2'b01) ? cur_wdata[(gi%2)*8 +: 8]
                              : cur_wdata[gi*8 +: 8];
  end

  // Load extraction with sign/zero extension
  logic [31:0] rd_word;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;
  assign rd_word = mem[cur_idx];
  assign ld_byte = rd_word[{cur_addr[1:0], 3'b000} +: 8];
  assign ld_half = rd_word[{cur_addr[1], 4'b0000} +: 16];

  // Select and extend the load result by funct3
  always_comb begin
    ld_data = '0;
    case (cur_funct3)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_data = {24'b0, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_data = {16'b0, ld_half};
      3'b010:  ld_data = rd_word;
      default: ld_data = '0;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= ST_IDLE;
    else      state_reg <= state_next;
  end

  // FSM next state, commit strobe and handshake outputs
  always_comb begin
    state_next    = state_reg;
    commit        = 1'b0;
    bus.req_ready = 1'b0;
    bus.busy      = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        bus.req_ready = 1'b1;
        bus.busy      = bus.req_valid;
        if (bus.req_valid) begin
          if (WAIT_CYCLES == 0) begin
            state_next = ST_RESP;
            commit     = 1'b1;
          end else begin
            state_next = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        bus.busy = 1'b1;
        if (count_reg == 4'd1) begin
          state_next = ST_RESP;
          commit     = 1'b1;
        end
      end
      ST_RESP: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Request capture and wait countdown
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg      <= '0;
      cap_we_reg     <= 1'b0;
      cap_funct3_reg <= '0;
      cap_addr_reg   <= '0;
      cap_wdata_reg  <= '0;
    end else if (state_reg == ST_IDLE && bus.req_valid) begin
      count_reg      <= 4'(WAIT_CYCLES);
      cap_we_reg     <= bus.req_we;
      cap_funct3_reg <= bus.req_funct3;
      cap_addr_reg   <= bus.req_addr;
      cap_wdata_reg  <= bus.req_wdata;
    end else if (state_reg == ST_WAIT) begin
      count_reg <= count_reg - 4'd1;
    end
  end

  // RAM byte-lane write on commit; contents are never reset, and a write is
  // suppressed while reset is asserted
  always_ff @(posedge clk) begin
    if (rst && commit && cur_we && !req_err) begin
      for (int i = 0; i < 4; i++) begin
        if (st_be[i]) mem[cur_idx][i*8 +: 8] <= st_data[i*8 +: 8];
      end
    end
  end

  // Response registers: strobe for one cycle, data held until the next response
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.resp_valid <= 1'b0;
      bus.resp_rdata <= '0;
      bus.resp_err   <= 1'b0;
    end else begin
      bus.resp_valid <= commit;
      if (commit) begin
        bus.resp_err   <= req_err;
        bus.resp_rdata <= (req_err || cur_we) ? 32'd0 : ld_data;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: dut0 (WAIT_CYCLES=2) runs a table of loads/stores with
// hand-computed results and per-transaction timing checks; dut1 (WAIT_CYCLES=0)
// shares the same request wires and is checked for back-to-back throughput.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  always #5 clk = ~clk;

  data_mem_responder_if bus0 ();
  data_mem_responder_if bus1 ();

  assign bus0.req_valid  = req_valid;
  assign bus0.req_we     = req_we;
  assign bus0.req_funct3 = req_funct3;
  assign bus0.req_addr   = req_addr;
  assign bus0.req_wdata  = req_wdata;
  assign bus1.req_valid  = req_valid;
  assign bus1.req_we     = req_we;
  assign bus1.req_funct3 = req_funct3;
  assign bus1.req_addr   = req_addr;
  assign bus1.req_wdata  = req_wdata;

  data_mem_responder #(.ADDR_W(8), .WAIT_CYCLES(2)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0)
  );
  data_mem_responder #(.ADDR_W(8), .WAIT_CYCLES(0)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1)
  );

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  localparam int NVEC = 23;
  vec_t tbl [NVEC];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // One request on dut0 (WAIT_CYCLES=2): accept edge, latency, busy profile,
  // single-cycle strobe, data and error.
  task automatic run_req(input int id, input vec_t v);
    logic [2:0]  busy_bits;
    logic        busy_resp;
    logic        rdy_resp;
    logic [31:0] rd;
    logic        er;
    int          lat;
    busy_bits = '0;
    busy_resp = 1'b1;
    rdy_resp  = 1'b1;
    rd        = 'x;
    er        = 1'bx;
    lat       = -1;
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = v.we;
    req_funct3 = v.f3;
    req_addr   = v.addr;
    req_wdata  = v.wdata;
    #1;
    chk($sformatf("txn%0d_ready_idle", id), {31'b0, bus0.req_ready}, 32'd1);
    busy_bits[0] = bus0.busy;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      if (k > 1) @(negedge clk);
      if (k <= 2) busy_bits[k[1:0]] = bus0.busy;
      if (bus0.resp_valid) begin
        lat       = k;
        rd        = bus0.resp_rdata;
        er        = bus0.resp_err;
        busy_resp = bus0.busy;
        rdy_resp  = bus0.req_ready;
        break;
      end
    end
    chk($sformatf("txn%0d_latency", id), 32'(lat), 32'd3);
    chk($sformatf("txn%0d_busy_c0_c2", id), {29'b0, busy_bits}, 32'h7);
    chk($sformatf("txn%0d_busy_resp", id), {31'b0, busy_resp}, 32'd0);
    chk($sformatf("txn%0d_ready_resp", id), {31'b0, rdy_resp}, 32'd0);
    chk($sformatf("txn%0d_rdata", id), rd, v.exp_rdata);
    chk($sformatf("txn%0d_err", id), {31'b0, er}, {31'b0, v.exp_err});
    @(negedge clk);
    chk($sformatf("txn%0d_strobe_one_cycle", id), {31'b0, bus0.resp_valid}, 32'd0);
    $display("txn %0d we=%0b f3=%03b addr=0x%08h wdata=0x%08h -> rdata=0x%08h err=%0b lat=%0d",
             id, v.we, v.f3, v.addr, v.wdata, rd, er, lat);
  endtask

  function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] exp_rdata,
                              input logic exp_err);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err;
    return v;
  endfunction

  // Bound the whole run
  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp6 [4];
    logic [31:0] addr6 [4];
    logic [7:0]  pat;
    logic        saw;
    int          k6;

    //        we    f3      addr     wdata          exp_rdata      err
    tbl[0]  = mk(1'b1, 3'b010, 32'h00, 32'h11223344, 32'h00000000, 1'b0);
    tbl[1]  = mk(1'b1, 3'b010, 32'h20, 32'h00000000, 32'h00000000, 1'b0);
    tbl[2]  = mk(1'b1, 3'b010, 32'h30, 32'hA5A55A5A, 32'h00000000, 1'b0);
    tbl[3]  = mk(1'b1, 3'b010, 32'h3C, 32'h0BADF00D, 32'h00000000, 1'b0);
    tbl[4]  = mk(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h00000000, 1'b0);
    tbl[5]  = mk(1'b0, 3'b010, 32'h10, 32'h00000000, 32'hDEADBEEF, 1'b0);
    tbl[6]  = mk(1'b1, 3'b000, 32'h13, 32'h12345680, 32'h00000000, 1'b0);
    tbl[7]  = mk(1'b0, 3'b000, 32'h13, 32'h00000000, 32'hFFFFFF80, 1'b0);
    tbl[8]  = mk(1'b0, 3'b100, 32'h13, 32'h00000000, 32'h00000080, 1'b0);
    tbl[9]  = mk(1'b0, 3'b010, 32'h10, 32'h00000000, 32'h80ADBEEF, 1'b0);
    tbl[10] = mk(1'b1, 3'b001, 32'h12, 32'hAAAA1234, 32'h00000000, 1'b0);
    tbl[11] = mk(1'b0, 3'b001, 32'h12, 32'h00000000, 32'h00001234, 1'b0);
    tbl[12] = mk(1'b0, 3'b101, 32'h10, 32'h00000000, 32'h0000BEEF, 1'b0);
    tbl[13] = mk(1'b1, 3'b001, 32'h12, 32'h55558001, 32'h00000000, 1'b0);
    tbl[14] = mk(1'b0, 3'b001, 32'h12, 32'h00000000, 32'hFFFF8001, 1'b0);
    tbl[15] = mk(1'b0, 3'b010, 32'h11, 32'h00000000, 32'h00000000, 1'b1);
    tbl[16] = mk(1'b1, 3'b010, 32'h102, 32'hCAFEF00D, 32'h00000000, 1'b1);
    tbl[17] = mk(1'b0, 3'b101, 32'h02, 32'h00000000, 32'h00001122, 1'b0);
    tbl[18] = mk(1'b0, 3'b010, 32'h00, 32'h00000000, 32'h11223344, 1'b0);
    tbl[19] = mk(1'b0, 3'b011, 32'h00, 32'h00000000, 32'h00000000, 1'b1);
    tbl[20] = mk(1'b1, 3'b100, 32'h00, 32'hFFFFFFFF, 32'h00000000, 1'b1);
    tbl[21] = mk(1'b0, 3'b010, 32'h00, 32'h00000000, 32'h11223344, 1'b0);
    tbl[22] = mk(1'b0, 3'b000, 32'h00, 32'h00000000, 32'h00000044, 1'b0);

    rst        = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = '0;
    req_wdata  = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_resp_valid", {31'b0, bus0.resp_valid}, 32'd0);
    chk("rst_resp_rdata", bus0.resp_rdata, 32'd0);
    chk("rst_resp_err", {31'b0, bus0.resp_err}, 32'd0);
    chk("rst_req_ready", {31'b0, bus0.req_ready}, 32'd1);
    chk("rst_busy", {31'b0, bus0.busy}, 32'd0);
    chk("rst_dut1_resp_valid", {31'b0, bus1.resp_valid}, 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < NVEC; i++) run_req(i, tbl[i]);

    // Reset in the middle of a store's WAIT: store dropped, outputs cleared
    run_req(100, mk(1'b0, 3'b010, 32'h10, 32'h0, 32'h8001BEEF, 1'b0));
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'b010;
    req_addr   = 32'h20;
    req_wdata  = 32'h00000055;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("abort_busy_in_wait", {31'b0, bus0.busy}, 32'd1);
    rst = 1'b0;
    #1;
    chk("abort_resp_valid", {31'b0, bus0.resp_valid}, 32'd0);
    chk("abort_resp_rdata", bus0.resp_rdata, 32'd0);
    chk("abort_resp_err", {31'b0, bus0.resp_err}, 32'd0);
    chk("abort_req_ready", {31'b0, bus0.req_ready}, 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    saw = 1'b0;
    repeat (5) begin
      @(negedge clk);
      saw = saw | bus0.resp_valid;
    end
    chk("abort_no_response", {31'b0, saw}, 32'd0);
    chk("abort_ready_after", {31'b0, bus0.req_ready}, 32'd1);
    chk("abort_busy_after", {31'b0, bus0.busy}, 32'd0);
    $display("txn abort: SW 0x55 @0x20 dropped by reset in WAIT");
    run_req(101, mk(1'b0, 3'b010, 32'h20, 32'h0, 32'h00000000, 1'b0));

    // dut1 (no wait cycles): four loads with req_valid held high
    addr6[0] = 32'h10; exp6[0] = 32'h8001BEEF;
    addr6[1] = 32'h00; exp6[1] = 32'h11223344;
    addr6[2] = 32'h30; exp6[2] = 32'hA5A55A5A;
    addr6[3] = 32'h3C; exp6[3] = 32'h0BADF00D;
    repeat (8) @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_funct3 = 3'b010;
    req_addr   = addr6[0];
    req_wdata  = '0;
    pat = '0;
    k6  = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      pat[c-1] = bus1.resp_valid;
      if (bus1.resp_valid) begin
        if (k6 < 4) begin
          chk($sformatf("b2b_rdata%0d", k6), bus1.resp_rdata, exp6[k6]);
          $display("txn b2b %0d addr=0x%08h -> rdata=0x%08h err=%0b cycle=%0d",
                   k6, addr6[k6], bus1.resp_rdata, bus1.resp_err, c);
        end
        k6++;
        if (k6 < 4) req_addr = addr6[k6];
        else        req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    chk("b2b_strobe_pattern", {24'b0, pat}, 32'h55);
    chk("b2b_response_count", 32'(k6), 32'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
